// File: rtl/pulse_interval_if.sv
// Handshake/result bundle between a pulse_interval block and its driver/consumer.
interface pulse_interval_if #(
    parameter int unsigned W = 15
) ();
    logic         start;
    logic         stop;
    logic         ack;
    logic         busy;
    logic         valid;
    logic [W-1:0] interval;
    logic         timeout;
    logic         in_win;
    logic         overrun;

    modport master (
        output start, stop, ack,
        input  busy, valid, interval, timeout, in_win, overrun
    );

    modport slave (
        input  start, stop, ack,
        output busy, valid, interval, timeout, in_win, overrun
    );
endinterface

// File: rtl/pulse_interval.sv
// Measures the clk-cycle distance from a start pulse to a stop pulse, with timeout,
// acceptance-window flag and a held result that the consumer acknowledges.
module pulse_interval #(
    parameter int unsigned W    = 15,
    parameter int unsigned TMAX = 25000,
    parameter int unsigned LO   = 10,
    parameter int unsigned HI   = 15
) (
    input  logic             clk,
    input  logic             reset,
    pulse_interval_if.slave  bus
);
    localparam logic [W-1:0] TMAX_W = W'(TMAX);
    localparam logic [W-1:0] LO_W   = W'(LO);
    localparam logic [W-1:0] HI_W   = W'(HI);
    localparam logic [W-1:0] ONE_W  = W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]   interval_q, interval_d;
    logic           timeout_q, timeout_d;
    logic           in_win_q, in_win_d;
    logic           overrun_q, overrun_d;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            interval_q <= '0;
            timeout_q  <= 1'b0;
            in_win_q   <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            interval_q <= interval_d;
            timeout_q  <= timeout_d;
            in_win_q   <= in_win_d;
            overrun_q  <= overrun_d;
        end
    end

    // Next-state and next-value logic; stop outranks start while running
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        interval_d = interval_q;
        timeout_d  = timeout_q;
        in_win_d   = in_win_q;
        overrun_d  = overrun_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    cnt_d   = ONE_W;
                end
            end
            RUN: begin
                if (bus.stop) begin
                    state_d    = HOLD;
                    interval_d = cnt_q;
                    timeout_d  = 1'b0;
                    in_win_d   = (cnt_q >= LO_W) && (cnt_q <= HI_W);
                end else if (bus.start) begin
                    cnt_d = ONE_W;
                end else if (cnt_q == TMAX_W) begin
                    state_d    = HOLD;
                    interval_d = TMAX_W;
                    timeout_d  = 1'b1;
                    in_win_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + ONE_W;
                end
            end
            HOLD: begin
                if (bus.ack) begin
                    overrun_d = 1'b0;
                    if (bus.start) begin
                        state_d = RUN;
                        cnt_d   = ONE_W;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (bus.start) begin
                    overrun_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy     = (state_q == RUN);
    assign bus.valid    = (state_q == HOLD);
    assign bus.interval = interval_q;
    assign bus.timeout  = timeout_q;
    assign bus.in_win   = in_win_q;
    assign bus.overrun  = overrun_q;
endmodule

// File: doc/pulse_interval.md
PULSE_INTERVAL -- requirements
Module: pulse_interval

Interface
REQ-001 Parameter W, default 15, width of the interval counter and result.
REQ-002 Parameter TMAX, default 25000, timeout count in clk cycles (500 us at 50 MHz); SHALL satisfy 1 <= TMAX <= 2^W-1.
REQ-003 Parameter LO, default 10, lower bound of the acceptance window in cycles, inclusive.
REQ-004 Parameter HI, default 15, upper bound of the acceptance window in cycles, inclusive.
REQ-005 clk  in  1  single clock; all state changes on the rising edge.
REQ-006 reset  in  1  synchronous, active-low reset; sampled only on the clk rising edge.
REQ-007 start  in  1  one-cycle pulse that opens a measurement.
REQ-008 stop  in  1  one-cycle pulse that closes a measurement.
REQ-009 ack  in  1  consumer acknowledge of a valid result.
REQ-010 busy  out  1  high while a measurement is running.
REQ-011 valid  out  1  high while a result is held.
REQ-012 interval  out  W  measured cycle count, meaningful while valid.
REQ-013 timeout  out  1  result closed by timeout, not by stop; meaningful while valid.
REQ-014 in_win  out  1  LO <= interval <= HI and timeout=0; meaningful while valid.
REQ-015 overrun  out  1  sticky flag: a start pulse was lost while a result was held.

Function
REQ-016 The block SHALL implement three states, IDLE, RUN and HOLD, and decode busy = RUN and valid = HOLD.
REQ-017 IDLE: start=1 -> RUN with cnt <= 1; stop is ignored in IDLE.
REQ-018 RUN: each cycle without an event SHALL do cnt <= cnt + 1.
REQ-019 Interval rule: start sampled at edge E0 and stop sampled at edge E0+N SHALL yield interval = N (N >= 1).
REQ-020 RUN with stop=1 -> HOLD with interval <= cnt and timeout <= 0.
REQ-021 RUN with stop=0, start=0 and cnt == TMAX -> HOLD with interval <= TMAX and timeout <= 1.
REQ-022 A stop at exactly E0+TMAX SHALL be a normal close: interval = TMAX, timeout = 0.
REQ-023 RUN with start=1 and stop=0 SHALL retrigger: cnt <= 1, remain in RUN, no flag raised.
REQ-024 RUN with start=1 and stop=1 in the same cycle: stop wins and the measurement closes per REQ-020; the start is dropped and overrun is not set.
REQ-025 HOLD: interval, timeout and in_win SHALL stay stable until ack; stop is ignored.
REQ-026 HOLD with ack=1, start=0 -> IDLE; overrun clears.
REQ-027 HOLD with ack=1, start=1 -> RUN with cnt <= 1; overrun clears.
REQ-028 HOLD with ack=0, start=1: the start is dropped, overrun <= 1, and the block stays in HOLD.
REQ-029 ack outside HOLD SHALL be ignored.
REQ-030 in_win SHALL be registered, computed from the captured value at the HOLD entry edge, with comparison unsigned on W bits.
REQ-031 cnt SHALL never exceed TMAX and SHALL never wrap.

Reset
REQ-032 reset=0 at a clk edge SHALL force IDLE, cnt=0, interval=0, timeout=0, in_win=0 and overrun=0, so busy=0 and valid=0.
REQ-033 reset SHALL take priority over start, stop and ack in the same cycle.
REQ-034 reset asserted mid-RUN or mid-HOLD SHALL discard the measurement with no result produced.
REQ-035 The first start is accepted on the first edge with reset=1.

Verification
REQ-036 start at edge 0, stop at edge 12 -> valid from edge 12 with interval=12, timeout=0, in_win=1; ack -> IDLE on the next edge.
REQ-037 start at edge 0, stop at edge 1 -> interval=1, in_win=0; start at edge 0, stop at edge 16 -> interval=16, in_win=0.
REQ-038 start at edge 0 with no stop -> HOLD at edge 25000 with interval=25000, timeout=1, in_win=0; a separate run with stop at edge 25000 -> timeout=0.
REQ-039 start at edge 0, start at edge 5, stop at edge 15 -> interval=10 (retrigger); start and stop at the same edge while in RUN -> stop wins, overrun=0.
REQ-040 In HOLD, start without ack -> overrun=1 and interval unchanged; ack with start at the same edge -> RUN with cnt=1 and overrun=0.
REQ-041 reset=0 at edge 7 of a running measurement -> IDLE at edge 7; a stop at edge 9 produces no valid.
